// File: rtl/esfa_cell_sequencer.sv
// Host-side sequencer for the MemoryCell command bus: one op at a time, broadcast, capture, reduce.
// INSERT runs as a free-cell scan followed by a one-edge update write and a release edge.
module esfa_cell_sequencer #(
  parameter int          N_CELLS  = 8,
  parameter int          RESP_LAT = 1,
  parameter logic [7:0]  IDLE_SEL = 8'd8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [7:0]             req_meta,
  input  logic [7:0]             req_index,
  input  logic [7:0]             req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic [7:0]             rsp_cell,
  output logic [7:0]             rsp_value,
  output logic [7:0]             rsp_context,
  output logic [7:0]             cell_selector,
  output logic [7:0]             cell_metadata,
  output logic                   cell_is_meta,
  output logic [7:0]             cell_index,
  output logic [7:0]             cell_value,
  input  logic [N_CELLS-1:0]     cell_bool,
  input  logic [8*N_CELLS-1:0]   cell_result,
  input  logic [8*N_CELLS-1:0]   cell_context
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [2:0] OP_LOOKUP    = 3'd0;
  localparam logic [2:0] OP_ENCODE    = 3'd1;
  localparam logic [2:0] OP_ENRANK    = 3'd2;
  localparam logic [2:0] OP_INSERT    = 3'd3;
  localparam logic [2:0] OP_CONG_UP   = 3'd4;
  localparam logic [2:0] OP_CONG_DOWN = 3'd5;
  localparam logic [2:0] OP_FREE_CNT  = 3'd6;

  localparam logic [7:0] SEL_UPDATE    = 8'd0;
  localparam logic [7:0] SEL_LOOKUP    = 8'd1;
  localparam logic [7:0] SEL_ENCODE    = 8'd2;
  localparam logic [7:0] SEL_CONG_UP   = 8'd3;
  localparam logic [7:0] SEL_CONG_DOWN = 8'd4;
  localparam logic [7:0] SEL_FREE      = 8'd5;
  localparam logic [7:0] SEL_ENRANK    = 8'd6;

  localparam logic [7:0] WAIT_INIT = 8'(RESP_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_hit_q, rsp_hit_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_cell_q, rsp_cell_d;
  logic [7:0]  rsp_value_q, rsp_value_d;
  logic [7:0]  rsp_context_q, rsp_context_d;
  logic [7:0]  sel_q, sel_d;
  logic [7:0]  meta_q, meta_d;
  logic        is_meta_q, is_meta_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  value_q, value_d;

  // Reduction over the sampled cell buses: priority to the lowest-numbered hit.
  logic        any_hit;
  logic [7:0]  low_idx;
  logic [7:0]  low_res;
  logic [7:0]  low_ctx;
  logic [7:0]  pop_cnt;

  always_comb begin
    any_hit = 1'b0;
    low_idx = 8'd0;
    low_res = 8'd0;
    low_ctx = 8'd0;
    pop_cnt = 8'd0;
    for (int k = 0; k < N_CELLS; k++) begin
      if (cell_bool[k] && !any_hit) begin
        any_hit = 1'b1;
        low_idx = 8'(k);
        low_res = cell_result[8*k +: 8];
        low_ctx = cell_context[8*k +: 8];
      end
      pop_cnt = pop_cnt + 8'(cell_bool[k]);
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_d        = wait_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_err_d     = rsp_err_q;
    rsp_cell_d    = rsp_cell_q;
    rsp_value_d   = rsp_value_q;
    rsp_context_d = rsp_context_q;
    sel_d         = sel_q;
    meta_d        = meta_q;
    is_meta_d     = is_meta_q;
    index_d       = index_q;
    value_d       = value_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          meta_d    = req_meta;
          index_d   = req_index;
          value_d   = req_value;
          is_meta_d = 1'b1;
          wait_d    = WAIT_INIT;
          state_d   = S_WAIT;
          case (req_op)
            OP_LOOKUP:    sel_d = SEL_LOOKUP;
            OP_ENCODE:    sel_d = SEL_ENCODE;
            OP_ENRANK:    sel_d = SEL_ENRANK;
            OP_INSERT:    sel_d = SEL_FREE;
            OP_FREE_CNT:  sel_d = SEL_FREE;
            OP_CONG_UP: begin
              sel_d   = SEL_CONG_UP;
              state_d = S_WRITE;
            end
            OP_CONG_DOWN: begin
              sel_d   = SEL_CONG_DOWN;
              state_d = S_WRITE;
            end
            default: begin
              // Reserved op: answer immediately, never touch the bus.
              sel_d         = IDLE_SEL;
              meta_d        = 8'd0;
              index_d       = 8'd0;
              value_d       = 8'd0;
              is_meta_d     = 1'b0;
              state_d       = S_RESP;
              rsp_valid_d   = 1'b1;
              rsp_err_d     = 1'b1;
              rsp_hit_d     = 1'b0;
              rsp_cell_d    = 8'd0;
              rsp_value_d   = 8'd0;
              rsp_context_d = 8'd0;
            end
          endcase
        end
      end

      S_WAIT: begin
        if (wait_q == 8'd0) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end

      S_CAPTURE: begin
        sel_d         = IDLE_SEL;
        is_meta_d     = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_hit_d     = any_hit;
        rsp_cell_d    = low_idx;
        rsp_value_d   = low_res;
        rsp_context_d = low_ctx;
        rsp_valid_d   = 1'b1;
        state_d       = S_RESP;
        if (op_q == OP_INSERT) begin
          if (!any_hit) begin
            rsp_err_d     = 1'b1;
            rsp_hit_d     = 1'b0;
            rsp_cell_d    = 8'd0;
            rsp_value_d   = 8'd0;
            rsp_context_d = 8'd0;
          end else begin
            // Update write to the free cell; its handle rides on the metadata bus.
            sel_d       = SEL_UPDATE;
            meta_d      = low_idx;
            is_meta_d   = 1'b1;
            rsp_valid_d = 1'b0;
            state_d     = S_WRITE;
          end
        end else if (op_q == OP_FREE_CNT) begin
          rsp_hit_d     = (pop_cnt != 8'd0);
          rsp_cell_d    = 8'd0;
          rsp_value_d   = pop_cnt;
          rsp_context_d = 8'd0;
        end
      end

      S_WRITE: begin
        sel_d     = IDLE_SEL;
        is_meta_d = 1'b0;
        state_d   = S_RELEASE;
      end

      S_RELEASE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_hit_d   = 1'b1;
        state_d     = S_RESP;
        if (op_q == OP_INSERT) begin
          rsp_cell_d    = meta_q;
          rsp_value_d   = meta_q;
          rsp_context_d = meta_q;
        end else begin
          rsp_cell_d    = 8'd0;
          rsp_value_d   = 8'd0;
          rsp_context_d = 8'd0;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_q          <= 3'd0;
      wait_q        <= 8'd0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_cell_q    <= 8'd0;
      rsp_value_q   <= 8'd0;
      rsp_context_q <= 8'd0;
      sel_q         <= IDLE_SEL;
      meta_q        <= 8'd0;
      is_meta_q     <= 1'b0;
      index_q       <= 8'd0;
      value_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_q        <= wait_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_err_q     <= rsp_err_d;
      rsp_cell_q    <= rsp_cell_d;
      rsp_value_q   <= rsp_value_d;
      rsp_context_q <= rsp_context_d;
      sel_q         <= sel_d;
      meta_q        <= meta_d;
      is_meta_q     <= is_meta_d;
      index_q       <= index_d;
      value_q       <= value_d;
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_cell      = rsp_cell_q;
  assign rsp_value     = rsp_value_q;
  assign rsp_context   = rsp_context_q;
  assign cell_selector = sel_q;
  assign cell_metadata = meta_q;
  assign cell_is_meta  = is_meta_q;
  assign cell_index    = index_q;
  assign cell_value    = value_q;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Directed bench for esfa_cell_sequencer; cell buses are driven straight from the bench.
module tb_esfa_cell_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [7:0]  req_meta = 8'd0;
  logic [7:0]  req_index = 8'd0;
  logic [7:0]  req_value = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic        rsp_err;
  logic [7:0]  rsp_cell;
  logic [7:0]  rsp_value;
  logic [7:0]  rsp_context;
  logic [7:0]  cell_selector;
  logic [7:0]  cell_metadata;
  logic        cell_is_meta;
  logic [7:0]  cell_index;
  logic [7:0]  cell_value;
  logic [7:0]  cell_bool = 8'd0;
  logic [63:0] cell_result = 64'd0;
  logic [63:0] cell_context = 64'd0;

  int errors = 0;
  int checks = 0;

  // Selector monitor, sampled mid-cycle.
  int   n_sel0 = 0;
  int   n_sel3 = 0;
  int   n_sel4 = 0;
  int   n_viol = 0;
  logic prev_wr = 1'b0;

  esfa_cell_sequencer #(.N_CELLS(8), .RESP_LAT(1), .IDLE_SEL(8'd8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_meta(req_meta), .req_index(req_index), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .rsp_cell(rsp_cell), .rsp_value(rsp_value), .rsp_context(rsp_context),
    .cell_selector(cell_selector), .cell_metadata(cell_metadata), .cell_is_meta(cell_is_meta),
    .cell_index(cell_index), .cell_value(cell_value),
    .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic wr_now;
    wr_now = (cell_selector == 8'd0) || (cell_selector == 8'd3) || (cell_selector == 8'd4);
    if (cell_selector == 8'd0) n_sel0++;
    if (cell_selector == 8'd3) n_sel3++;
    if (cell_selector == 8'd4) n_sel4++;
    if (wr_now && prev_wr) n_viol++;
    prev_wr = wr_now;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the accepting edge (edge A).
  task automatic issue(input logic [2:0] op, input logic [7:0] meta,
                       input logic [7:0] idx, input logic [7:0] val);
    int n;
    req_op = op; req_meta = meta; req_index = idx; req_value = val;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL issue_ready: req_ready=%0b, wanted 1 within 20 cycles", req_ready);
    end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL handshake: rsp_valid=%0b req_ready=%0b, wanted 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || cell_selector !== 8'd8) begin
      errors++; $display("FAIL reset_hold: ready=%0b rsp_valid=%0b sel=%0d, wanted 0/0/8", req_ready, rsp_valid, cell_selector);
    end
    checks++;
    if (cell_metadata !== 8'd0 || cell_is_meta !== 1'b0 || cell_index !== 8'd0 || cell_value !== 8'd0 ||
        rsp_hit !== 1'b0 || rsp_err !== 1'b0 || rsp_cell !== 8'd0 || rsp_value !== 8'd0 || rsp_context !== 8'd0) begin
      errors++; $display("FAIL reset_values: meta=%0h ism=%0b idx=%0h val=%0h hit=%0b err=%0b cell=%0h rv=%0h ctx=%0h, wanted all 0",
                         cell_metadata, cell_is_meta, cell_index, cell_value, rsp_hit, rsp_err, rsp_cell, rsp_value, rsp_context);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || cell_selector !== 8'd8) begin
      errors++; $display("FAIL reset_release: ready=%0b sel=%0d, wanted 1/8", req_ready, cell_selector);
    end
  endtask

  task automatic test_lookup();
    cell_bool = 8'b0010_0100;
    cell_result = 64'd0;  cell_result[23:16] = 8'h11;  cell_result[47:40] = 8'h22;
    cell_context = 64'd0; cell_context[23:16] = 8'h33; cell_context[47:40] = 8'h44;
    issue(3'd0, 8'h07, 8'h01, 8'h02);
    checks++;
    if (cell_selector !== 8'd1 || cell_metadata !== 8'h07 || cell_is_meta !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL lookup_bcast: sel=%0d meta=%0h ism=%0b ready=%0b, wanted 1/07/1/0", cell_selector, cell_metadata, cell_is_meta, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL lookup_early: rsp_valid=%0b at A+1, wanted 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_cell !== 8'd2 || rsp_value !== 8'h11 || rsp_context !== 8'h33 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL lookup_rsp: v=%0b hit=%0b cell=%0d val=%0h ctx=%0h err=%0b, wanted 1/1/2/11/33/0",
                         rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context, rsp_err);
    end
    checks++;
    if (cell_selector !== 8'd8 || cell_is_meta !== 1'b0) begin
      errors++; $display("FAIL lookup_idle: sel=%0d ism=%0b, wanted 8/0", cell_selector, cell_is_meta);
    end
    handshake();
  endtask

  task automatic test_enrank_miss();
    cell_bool = 8'd0;
    issue(3'd2, 8'h01, 8'h02, 8'h03);
    checks++;
    if (cell_selector !== 8'd6) begin
      errors++; $display("FAIL enrank_sel: sel=%0d, wanted 6", cell_selector);
    end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_cell !== 8'd0 || rsp_value !== 8'd0 || rsp_context !== 8'd0) begin
      errors++; $display("FAIL enrank_miss: v=%0b hit=%0b cell=%0d val=%0h ctx=%0h, wanted 1/0/0/0/0",
                         rsp_valid, rsp_hit, rsp_cell, rsp_value, rsp_context);
    end
    handshake();
  endtask

  task automatic run_insert(input logic [7:0] free_bits, input logic [7:0] f);
    cell_bool = free_bits;
    issue(3'd3, 8'hAA, 8'd3, 8'h40);
    checks++;
    if (cell_selector !== 8'd5) begin
      errors++; $display("FAIL insert_scan: sel=%0d, wanted 5", cell_selector);
    end
    tick(); tick();
    checks++;
    if (cell_selector !== 8'd0 || cell_metadata !== f || cell_index !== 8'd3 || cell_value !== 8'h40 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL insert_write: sel=%0d meta=%0d idx=%0d val=%0h v=%0b, wanted 0/%0d/3/40/0",
                         cell_selector, cell_metadata, cell_index, cell_value, rsp_valid, f);
    end
    tick();
    checks++;
    if (cell_selector !== 8'd8 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL insert_release: sel=%0d v=%0b, wanted 8/0", cell_selector, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_err !== 1'b0 || rsp_cell !== f || rsp_value !== f || rsp_context !== f) begin
      errors++; $display("FAIL insert_rsp: v=%0b hit=%0b err=%0b cell=%0d val=%0d ctx=%0d, wanted 1/1/0/%0d/%0d/%0d",
                         rsp_valid, rsp_hit, rsp_err, rsp_cell, rsp_value, rsp_context, f, f, f);
    end
    handshake();
  endtask

  task automatic test_insert();
    run_insert(8'hFF, 8'd0);
    run_insert(8'hFE, 8'd1);
  endtask

  task automatic test_insert_full();
    int s0;
    s0 = n_sel0;
    cell_bool = 8'd0;
    issue(3'd3, 8'h00, 8'd3, 8'h40);
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_hit !== 1'b0 || rsp_cell !== 8'd0) begin
      errors++; $display("FAIL insert_full: v=%0b err=%0b hit=%0b cell=%0d, wanted 1/1/0/0", rsp_valid, rsp_err, rsp_hit, rsp_cell);
    end
    tick();
    handshake();
    checks++;
    if (n_sel0 != s0) begin
      errors++; $display("FAIL insert_full_nowrite: update selector seen %0d times, wanted 0", n_sel0 - s0);
    end
  endtask

  task automatic test_reset_mid_insert();
    int s0;
    s0 = n_sel0;
    cell_bool = 8'hFF;
    issue(3'd3, 8'h00, 8'd9, 8'h55);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (cell_selector !== 8'd8 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: sel=%0d v=%0b ready=%0b, wanted 8/0/1", cell_selector, rsp_valid, req_ready);
    end
    tick(); tick();
    checks++;
    if (n_sel0 != s0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_nowrite: writes=%0d v=%0b, wanted 0/0", n_sel0 - s0, rsp_valid);
    end
  endtask

  task automatic test_free_count();
    cell_bool = 8'b1011_0010;
    cell_result = {8{8'h5A}};
    cell_context = {8{8'hA5}};
    issue(3'd6, 8'h00, 8'h00, 8'h00);
    checks++;
    if (cell_selector !== 8'd5) begin
      errors++; $display("FAIL freecnt_sel: sel=%0d, wanted 5", cell_selector);
    end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_value !== 8'd4 || rsp_hit !== 1'b1 || rsp_cell !== 8'd0 || rsp_context !== 8'd0) begin
      errors++; $display("FAIL freecnt_4: v=%0b val=%0d hit=%0b cell=%0d ctx=%0h, wanted 1/4/1/0/0",
                         rsp_valid, rsp_value, rsp_hit, rsp_cell, rsp_context);
    end
    handshake();
    cell_bool = 8'd0;
    issue(3'd6, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_value !== 8'd0 || rsp_hit !== 1'b0) begin
      errors++; $display("FAIL freecnt_0: v=%0b val=%0d hit=%0b, wanted 1/0/0", rsp_valid, rsp_value, rsp_hit);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int s3, s4, sv;
    s3 = n_sel3; s4 = n_sel4; sv = n_viol;
    cell_bool = 8'hFF;
    issue(3'd4, 8'h12, 8'h00, 8'h00);
    checks++;
    if (cell_selector !== 8'd3 || cell_metadata !== 8'h12) begin
      errors++; $display("FAIL congup_sel: sel=%0d meta=%0h, wanted 3/12", cell_selector, cell_metadata);
    end
    tick();
    checks++;
    if (cell_selector !== 8'd8 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL congup_release: sel=%0d v=%0b, wanted 8/0", cell_selector, rsp_valid);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_err !== 1'b0 || rsp_cell !== 8'd0 || rsp_value !== 8'd0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL congup_stall%0d: v=%0b hit=%0b err=%0b cell=%0d val=%0d ready=%0b, wanted 1/1/0/0/0/0",
                           i, rsp_valid, rsp_hit, rsp_err, rsp_cell, rsp_value, req_ready);
      end
      tick();
    end
    handshake();
    issue(3'd5, 8'h12, 8'h00, 8'h00);
    checks++;
    if (cell_selector !== 8'd4) begin
      errors++; $display("FAIL congdown_sel: sel=%0d, wanted 4", cell_selector);
    end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin
      errors++; $display("FAIL congdown_rsp: v=%0b hit=%0b, wanted 1/1", rsp_valid, rsp_hit);
    end
    handshake();
    tick();
    checks++;
    if (n_sel3 - s3 != 1 || n_sel4 - s4 != 1 || n_viol != sv) begin
      errors++; $display("FAIL cong_pulses: sel3=%0d sel4=%0d held=%0d, wanted 1/1/0", n_sel3 - s3, n_sel4 - s4, n_viol - sv);
    end
  endtask

  task automatic test_reserved();
    int s3, s4, s0;
    s0 = n_sel0; s3 = n_sel3; s4 = n_sel4;
    issue(3'd7, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_hit !== 1'b0 || rsp_value !== 8'd0 || rsp_cell !== 8'd0 || cell_selector !== 8'd8) begin
      errors++; $display("FAIL reserved_op: v=%0b err=%0b hit=%0b val=%0d cell=%0d sel=%0d, wanted 1/1/0/0/0/8",
                         rsp_valid, rsp_err, rsp_hit, rsp_value, rsp_cell, cell_selector);
    end
    handshake();
    checks++;
    if (n_sel0 != s0 || n_sel3 != s3 || n_sel4 != s4) begin
      errors++; $display("FAIL reserved_nobus: write selectors seen, wanted none");
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_enrank_miss();
    test_insert();
    test_insert_full();
    test_reset_mid_insert();
    test_free_count();
    test_back_to_back();
    test_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
